// File: rtl/apb_master_rw.sv
// APB master: valid/ready request in, APB read/write out; accept->SETUP->ACCESS, response registered one cycle after completion.
// req_ready high in IDLE and in the completing ACCESS cycle (back-to-back); responses have no backpressure.
module apb_master_rw #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int NUM_SLV = 4,
    parameter int SEL_W   = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1,
    parameter int TIMEOUT = 16
) (
    input  logic                  pclk,
    input  logic                  presetn,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [SEL_W-1:0]      req_sel,
    input  logic                  req_write,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [DATA_W/8-1:0]   req_strb,
    output logic                  rsp_valid,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_timeout,
    output logic [NUM_SLV-1:0]    psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [ADDR_W-1:0]     paddr,
    output logic [DATA_W-1:0]     pwdata,
    output logic [DATA_W/8-1:0]   pstrb,
    input  logic                  pready,
    input  logic                  pslverr,
    input  logic [DATA_W-1:0]     prdata
);

    localparam int STRB_W = DATA_W / 8;
    localparam int CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETUP  = 2'd1;
    localparam logic [1:0] S_ACCESS = 2'd2;

    logic [1:0]         r_state;
    logic               r_bad;
    logic [CNT_W-1:0]   r_cnt;
    logic [NUM_SLV-1:0] r_psel;
    logic               r_penable;
    logic               r_pwrite;
    logic [ADDR_W-1:0]  r_paddr;
    logic [DATA_W-1:0]  r_pwdata;
    logic [STRB_W-1:0]  r_pstrb;
    logic               r_rsp_vld;
    logic [DATA_W-1:0]  r_rsp_rdata;
    logic               r_rsp_err;
    logic               r_rsp_to;

    logic               w_access;
    logic               w_to;
    logic               w_done;
    logic               w_err;
    logic               w_accept;
    logic               w_bad_sel;
    logic [NUM_SLV-1:0] w_psel_dec;

    always_comb begin
        w_psel_dec = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (int'(req_sel) == i) w_psel_dec[i] = 1'b1;
        end
    end

    assign w_bad_sel = (int'(req_sel) >= NUM_SLV);
    assign w_access  = (r_state == S_ACCESS);
    // Abort in the TIMEOUT-th ACCESS cycle: r_cnt holds the low-pready cycles already seen.
    assign w_to      = (TIMEOUT > 0) && w_access && !r_bad && !pready &&
                       ((int'(r_cnt) + 1) >= TIMEOUT);
    assign w_done    = w_access && (r_bad || pready || w_to);
    assign w_err     = r_bad || w_to || pslverr;
    assign req_ready = (r_state == S_IDLE) || w_done;
    assign w_accept  = req_valid && req_ready;

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_state     <= S_IDLE;
            r_bad       <= 1'b0;
            r_cnt       <= '0;
            r_psel      <= '0;
            r_penable   <= 1'b0;
            r_pwrite    <= 1'b0;
            r_paddr     <= '0;
            r_pwdata    <= '0;
            r_pstrb     <= '0;
            r_rsp_vld   <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
            r_rsp_to    <= 1'b0;
        end else begin
            r_rsp_vld <= w_done;
            if (w_done) begin
                r_rsp_err   <= w_err;
                r_rsp_to    <= w_to;
                r_rsp_rdata <= (!r_pwrite && !w_err) ? prdata : '0;
            end

            if (w_accept) begin
                r_state   <= S_SETUP;
                r_bad     <= w_bad_sel;
                r_psel    <= w_psel_dec;
                r_penable <= 1'b0;
                r_pwrite  <= req_write;
                r_paddr   <= req_addr;
                r_pwdata  <= req_wdata;
                r_pstrb   <= req_write ? req_strb : '0;
            end else begin
                case (r_state)
                    S_SETUP: begin
                        r_state   <= S_ACCESS;
                        r_penable <= 1'b1;
                        r_cnt     <= '0;
                    end
                    S_ACCESS: begin
                        if (w_done) begin
                            r_state   <= S_IDLE;
                            r_psel    <= '0;
                            r_penable <= 1'b0;
                        end else if (!pready && (int'(r_cnt) < TIMEOUT)) begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign psel        = r_psel;
    assign penable     = r_penable;
    assign pwrite      = r_pwrite;
    assign paddr       = r_paddr;
    assign pwdata      = r_pwdata;
    assign pstrb       = r_pstrb;
    assign rsp_valid   = r_rsp_vld;
    assign rsp_rdata   = r_rsp_rdata;
    assign rsp_err     = r_rsp_err;
    assign rsp_timeout = r_rsp_to;

endmodule

// File: tb/tb_apb_master_rw.sv
// Bench for apb_master_rw: directed and random transfers against a latency/response model; inputs driven and outputs sampled on the falling edge.
module tb_apb_master_rw;

    localparam int TO = 16;

    logic        pclk;
    logic        presetn;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_sel;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_strb;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;
    logic [3:0]  psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic        pready;
    logic        pslverr;
    logic [31:0] prdata;

    int checks   = 0;
    int failures = 0;

    apb_master_rw #(
        .ADDR_W(32), .DATA_W(32), .NUM_SLV(4), .SEL_W(3), .TIMEOUT(TO)
    ) dut (
        .pclk(pclk), .presetn(presetn),
        .req_valid(req_valid), .req_ready(req_ready), .req_sel(req_sel),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_strb(req_strb),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .rsp_timeout(rsp_timeout),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
        .pwdata(pwdata), .pstrb(pstrb),
        .pready(pready), .pslverr(pslverr), .prdata(prdata)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One transfer with the bench acting as the slave; waits = ACCESS cycles with pready low.
    task automatic xfer(input logic [2:0] sel, input bit wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] strb,
                        input int waits, input bit slverr, input logic [31:0] rd);
        bit          bad, tmo, exp_err, got;
        int          exp_acc, exp_lat, n, acc;
        logic [3:0]  exp_psel;
        logic [31:0] exp_rdata;
        bad       = (sel >= 3'd4);
        tmo       = !bad && (waits >= TO);
        exp_acc   = bad ? 1 : (tmo ? TO : waits + 1);
        exp_lat   = exp_acc + 2;
        exp_err   = bad || tmo || slverr;
        exp_rdata = (!wr && !exp_err) ? rd : 32'h0;
        exp_psel  = bad ? 4'h0 : (4'h1 << sel);

        @(negedge pclk);
        req_valid = 1'b1; req_sel = sel; req_write = wr; req_addr = addr;
        req_wdata = wdata; req_strb = strb;
        #1 chk("req_ready_idle", {31'h0, req_ready}, 32'h1);
        n = 0; acc = 0; got = 0;
        while (!got && n < 60) begin
            @(negedge pclk);
            n++;
            req_valid = 1'b0;
            if (rsp_valid) begin
                got = 1;
                chk("latency", n, exp_lat);
                chk("acc_cycles", acc, exp_acc);
                chk("rsp_err", {31'h0, rsp_err}, {31'h0, exp_err});
                chk("rsp_timeout", {31'h0, rsp_timeout}, {31'h0, tmo});
                chk("rsp_rdata", rsp_rdata, exp_rdata);
                chk("idle_psel", {28'h0, psel}, 32'h0);
                chk("idle_penable", {31'h0, penable}, 32'h0);
                chk("idle_ready", {31'h0, req_ready}, 32'h1);
            end else begin
                chk("psel", {28'h0, psel}, {28'h0, exp_psel});
                chk("paddr", paddr, addr);
                chk("pwrite", {31'h0, pwrite}, {31'h0, wr});
                chk("pstrb", {28'h0, pstrb}, wr ? {28'h0, strb} : 32'h0);
                if (n == 1) begin
                    chk("setup_penable", {31'h0, penable}, 32'h0);
                    if (wr) chk("pwdata", pwdata, wdata);
                end else begin
                    chk("access_penable", {31'h0, penable}, 32'h1);
                    acc++;
                end
            end
            if (penable) begin
                pready  = (acc == waits + 1);
                pslverr = slverr && pready;
                prdata  = rd;
            end else begin
                pready  = 1'b0;
                pslverr = 1'b0;
            end
        end
        chk("rsp_seen", {31'h0, got}, 32'h1);
        pready = 1'b0; pslverr = 1'b0;
    endtask

    initial begin
        presetn = 1'b0; req_valid = 1'b0; req_sel = '0; req_write = 1'b0;
        req_addr = '0; req_wdata = '0; req_strb = '0;
        pready = 1'b0; pslverr = 1'b0; prdata = '0;

        #3;
        chk("rst_psel", {28'h0, psel}, 32'h0);
        chk("rst_penable", {31'h0, penable}, 32'h0);
        chk("rst_pwrite", {31'h0, pwrite}, 32'h0);
        chk("rst_paddr", paddr, 32'h0);
        chk("rst_pwdata", pwdata, 32'h0);
        chk("rst_pstrb", {28'h0, pstrb}, 32'h0);
        chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        chk("rst_rsp_rdata", rsp_rdata, 32'h0);
        chk("rst_rsp_err", {30'h0, rsp_err, rsp_timeout}, 32'h0);
        repeat (2) @(negedge pclk);
        presetn = 1'b1;
        #1 chk("rst_ready", {31'h0, req_ready}, 32'h1);

        // Directed cases
        xfer(3'd2, 1'b1, 32'h1000, 32'hDEADBEEF, 4'hF, 0, 1'b0, 32'h0);
        xfer(3'd1, 1'b0, 32'h2000, 32'h0, 4'hF, 3, 1'b0, 32'h12345678);
        xfer(3'd0, 1'b0, 32'h3000, 32'h0, 4'h0, 1, 1'b1, 32'hCAFEF00D);
        xfer(3'd5, 1'b0, 32'h4000, 32'h0, 4'h0, 99, 1'b0, 32'h55AA55AA);
        xfer(3'd3, 1'b0, 32'h5000, 32'h0, 4'h0, 99, 1'b0, 32'hA5A5A5A5);
        xfer(3'd3, 1'b0, 32'h5004, 32'h0, 4'h0, TO - 1, 1'b0, 32'h0BADCAFE);

        // Back-to-back: write then read with req_valid held
        @(negedge pclk);
        req_valid = 1'b1; req_sel = 3'd2; req_write = 1'b1; req_addr = 32'h6000;
        req_wdata = 32'h11112222; req_strb = 4'h3;
        @(negedge pclk);
        chk("b2b_setup1_psel", {28'h0, psel}, 32'h4);
        chk("b2b_setup1_pen", {31'h0, penable}, 32'h0);
        chk("b2b_setup1_ready", {31'h0, req_ready}, 32'h0);
        req_write = 1'b0; req_addr = 32'h6004;
        @(negedge pclk);
        chk("b2b_access1_pen", {31'h0, penable}, 32'h1);
        chk("b2b_access1_pwrite", {31'h0, pwrite}, 32'h1);
        pready = 1'b1;
        #1 chk("b2b_comb_ready", {31'h0, req_ready}, 32'h1);
        @(negedge pclk);
        pready = 1'b0; req_valid = 1'b0;
        chk("b2b_rsp1", {31'h0, rsp_valid}, 32'h1);
        chk("b2b_rsp1_err", {31'h0, rsp_err}, 32'h0);
        chk("b2b_setup2_psel", {28'h0, psel}, 32'h4);
        chk("b2b_setup2_pen", {31'h0, penable}, 32'h0);
        chk("b2b_setup2_paddr", paddr, 32'h6004);
        chk("b2b_setup2_pstrb", {28'h0, pstrb}, 32'h0);
        @(negedge pclk);
        chk("b2b_gap", {31'h0, rsp_valid}, 32'h0);
        chk("b2b_access2_pen", {31'h0, penable}, 32'h1);
        pready = 1'b1; prdata = 32'h77778888;
        @(negedge pclk);
        pready = 1'b0;
        chk("b2b_rsp2", {31'h0, rsp_valid}, 32'h1);
        chk("b2b_rsp2_rdata", rsp_rdata, 32'h77778888);
        chk("b2b_idle_psel", {28'h0, psel}, 32'h0);

        // Reset during ACCESS
        @(negedge pclk);
        req_valid = 1'b1; req_sel = 3'd1; req_write = 1'b1; req_addr = 32'h7000;
        req_wdata = 32'h99999999; req_strb = 4'hF;
        @(negedge pclk);
        req_valid = 1'b0;
        repeat (2) @(negedge pclk);
        chk("rstmid_in_access", {31'h0, penable}, 32'h1);
        #2 presetn = 1'b0;
        #1;
        chk("rstmid_psel", {28'h0, psel}, 32'h0);
        chk("rstmid_penable", {31'h0, penable}, 32'h0);
        pready = 1'b1;
        repeat (2) begin
            @(negedge pclk);
            chk("rstmid_no_rsp", {31'h0, rsp_valid}, 32'h0);
        end
        pready = 1'b0;
        presetn = 1'b1;
        repeat (3) begin
            @(negedge pclk);
            chk("rstmid_no_rsp_after", {31'h0, rsp_valid}, 32'h0);
            chk("rstmid_ready", {31'h0, req_ready}, 32'h1);
        end
        xfer(3'd1, 1'b1, 32'h7000, 32'h13579BDF, 4'hF, 0, 1'b0, 32'h0);

        // Random transfers against the model
        for (int t = 0; t < 24; t++) begin
            logic [2:0]  s;
            bit          w, e;
            int          r, wt;
            s  = 3'($urandom_range(0, 5));
            w  = bit'($urandom_range(0, 1));
            r  = $urandom_range(0, 11);
            wt = (r < 9) ? (r % 5) : ((r == 9) ? TO - 1 : TO + 2);
            e  = ($urandom_range(0, 3) == 0);
            xfer(s, w, $urandom, $urandom, 4'($urandom_range(0, 15)), wt, e, $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
